enemy_pool_manager: RTL and testbench

Parametrised successor to the fixed 8-slot enemy controller. Owns a pool of N_SLOTS enemy slots, each with its own lifecycle FSM and per-slot health, type and state. Spawns enemies to hold a minimum population and adds timed extra spawns up to a ceiling. Applies projectile hits, handles enemies that escape, and keeps score and escape counters for the game-state and renderer blocks.

---
 rtl/enemy_pool_manager.sv | 179 +++++++++++++++++
 tb/tb_enemy_pool_manager.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_pool_manager.sv
// Enemy slot pool: per-slot lifecycle FSM, health/type tracking, population-driven
// and timed spawning, projectile hits, escapes, and saturating score/escape counters.
module enemy_pool_manager #(
    parameter int N_SLOTS      = 8,
    parameter int IDX_W        = 3,
    parameter int MIN_ACTIVE   = 2,
    parameter int MAX_ACTIVE   = 6,
    parameter int HEALTH_W     = 4,
    parameter int SPAWN_PERIOD = 50000000,
    parameter int DEATH_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hit_valid,
    input  logic [IDX_W-1:0]             hit_idx,
    input  logic [HEALTH_W-1:0]          hit_dmg,
    input  logic                         escape_valid,
    input  logic [IDX_W-1:0]             escape_idx,
    output logic [N_SLOTS-1:0]           active,
    output logic [N_SLOTS-1:0]           dying,
    output logic [N_SLOTS*HEALTH_W-1:0]  health,
    output logic [N_SLOTS*2-1:0]         etype,
    output logic [IDX_W:0]               active_count,
    output logic                         spawn_pulse,
    output logic [IDX_W-1:0]             spawn_idx,
    output logic                         kill_pulse,
    output logic [15:0]                  score,
    output logic [7:0]                   escaped
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_ACTIVE, SLOT_DYING} slot_state_t;

    localparam int TIMER_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int DC_W    = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [IDX_W:0]     MIN_CNT    = (IDX_W+1)'(MIN_ACTIVE);
    localparam logic [IDX_W:0]     MAX_CNT    = (IDX_W+1)'(MAX_ACTIVE);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SPAWN_PERIOD - 1);
    localparam logic [DC_W-1:0]    DC_LAST    = DC_W'(DEATH_CYCLES - 1);

    slot_state_t         state_q [N_SLOTS];
    slot_state_t         state_d [N_SLOTS];
    logic [HEALTH_W-1:0] hp_q    [N_SLOTS];
    logic [HEALTH_W-1:0] hp_d    [N_SLOTS];
    logic [HEALTH_W-1:0] hp_hit  [N_SLOTS];
    logic [1:0]          type_q  [N_SLOTS];
    logic [1:0]          type_d  [N_SLOTS];
    logic [DC_W-1:0]     dcnt_q  [N_SLOTS];
    logic [DC_W-1:0]     dcnt_d  [N_SLOTS];
    logic [N_SLOTS-1:0]  hit_here;
    logic [N_SLOTS-1:0]  esc_here;

    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [7:0]          lfsr_q;
    logic                spawn_d, want_spawn, free_found;
    logic [IDX_W-1:0]    spawn_idx_d;
    logic                kill_d, esc_d;
    logic [1:0]          kill_type;
    logic [16:0]         score_sum;
    logic [15:0]         score_d;
    logic [7:0]          escaped_d;
    logic [IDX_W:0]      count_d;

    // Spawn choice looks only at registered state, so a slot freed this edge waits a cycle.
    always_comb begin
        want_spawn  = (active_count < MIN_CNT) ||
                      ((timer_q == TIMER_LAST) && (active_count < MAX_CNT));
        free_found  = 1'b0;
        spawn_idx_d = '0;
        for (int unsigned i = N_SLOTS; i > 0; i--) begin
            if (state_q[i-1] == SLOT_FREE) begin
                free_found  = 1'b1;
                spawn_idx_d = IDX_W'(i-1);
            end
        end
        spawn_d = want_spawn && free_found;
    end

    always_comb begin
        kill_d    = 1'b0;
        esc_d     = 1'b0;
        kill_type = '0;
        count_d   = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            state_d[i]  = state_q[i];
            hp_d[i]     = hp_q[i];
            type_d[i]   = type_q[i];
            dcnt_d[i]   = dcnt_q[i];
            hit_here[i] = hit_valid && (hit_idx == IDX_W'(i)) && (hit_dmg != '0) &&
                          (state_q[i] == SLOT_ACTIVE);
            esc_here[i] = escape_valid && (escape_idx == IDX_W'(i)) &&
                          (state_q[i] == SLOT_ACTIVE);
            hp_hit[i]   = (hp_q[i] > hit_dmg) ? hp_q[i] - hit_dmg : '0;
            case (state_q[i])
                SLOT_FREE: begin
                    if (spawn_d && (spawn_idx_d == IDX_W'(i))) begin
                        state_d[i] = SLOT_ACTIVE;
                        type_d[i]  = lfsr_q[1:0];
                        hp_d[i]    = HEALTH_W'(1) << lfsr_q[1:0];
                    end
                end
                SLOT_ACTIVE: begin
                    // A killing hit outranks an escape; a surviving hit loses to one.
                    if (hit_here[i] && (hp_hit[i] == '0)) begin
                        state_d[i] = SLOT_DYING;
                        hp_d[i]    = '0;
                        dcnt_d[i]  = '0;
                        kill_d     = 1'b1;
                        kill_type  = type_q[i];
                    end else if (esc_here[i]) begin
                        state_d[i] = SLOT_FREE;
                        hp_d[i]    = '0;
                        esc_d      = 1'b1;
                    end else if (hit_here[i]) begin
                        hp_d[i] = hp_hit[i];
                    end
                end
                SLOT_DYING: begin
                    if (dcnt_q[i] == DC_LAST) state_d[i] = SLOT_FREE;
                    else                      dcnt_d[i]  = dcnt_q[i] + DC_W'(1);
                end
                default: state_d[i] = SLOT_FREE;
            endcase
            if (state_d[i] == SLOT_ACTIVE) count_d = count_d + (IDX_W+1)'(1);
        end

        score_sum = {1'b0, score} + 17'(kill_type) + 17'd1;
        score_d   = !kill_d ? score : (score_sum[16] ? '1 : score_sum[15:0]);
        escaped_d = (esc_d && (escaped != '1)) ? escaped + 8'd1 : escaped;

        if (spawn_d || (timer_q == TIMER_LAST)) timer_d = '0;
        else                                    timer_d = timer_q + TIMER_W'(1);
    end

    always_comb begin
        active = '0;
        dying  = '0;
        health = '0;
        etype  = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            active[i]                       = (state_q[i] == SLOT_ACTIVE);
            dying[i]                        = (state_q[i] == SLOT_DYING);
            health[i*HEALTH_W +: HEALTH_W]  = hp_q[i];
            etype[2*i +: 2]                 = type_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
                hp_q[i]    <= '0;
                type_q[i]  <= '0;
                dcnt_q[i]  <= '0;
            end
            timer_q      <= '0;
            lfsr_q       <= 8'hA5;
            score        <= '0;
            escaped      <= '0;
            active_count <= '0;
            spawn_pulse  <= 1'b0;
            spawn_idx    <= '0;
            kill_pulse   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            type_q       <= type_d;
            dcnt_q       <= dcnt_d;
            timer_q      <= timer_d;
            lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            score        <= score_d;
            escaped      <= escaped_d;
            active_count <= count_d;
            spawn_pulse  <= spawn_d;
            spawn_idx    <= spawn_idx_d;
            kill_pulse   <= kill_d;
        end
    end

endmodule

// File: tb/tb_enemy_pool_manager.sv
// Bench for enemy_pool_manager: an 8-slot instance with a short spawn period and a
// fully-populated 4-slot instance; spawn/kill events are scoreboarded by edge number.
module tb_enemy_pool_manager;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 8 slots, MIN 2, MAX 6, spawn period 10, 16-cycle death.
    logic        a_hit_valid = 1'b0, a_escape_valid = 1'b0;
    logic [2:0]  a_hit_idx = '0, a_escape_idx = '0;
    logic [3:0]  a_hit_dmg = '0;
    logic [7:0]  a_active, a_dying;
    logic [31:0] a_health;
    logic [15:0] a_etype;
    logic [3:0]  a_count;
    logic        a_spawn_pulse, a_kill_pulse;
    logic [2:0]  a_spawn_idx;
    logic [15:0] a_score;
    logic [7:0]  a_escaped;

    enemy_pool_manager #(
        .N_SLOTS(8), .IDX_W(3), .MIN_ACTIVE(2), .MAX_ACTIVE(6),
        .HEALTH_W(4), .SPAWN_PERIOD(10), .DEATH_CYCLES(16)
    ) dut_a (
        .clk(clk), .reset(reset),
        .hit_valid(a_hit_valid), .hit_idx(a_hit_idx), .hit_dmg(a_hit_dmg),
        .escape_valid(a_escape_valid), .escape_idx(a_escape_idx),
        .active(a_active), .dying(a_dying), .health(a_health), .etype(a_etype),
        .active_count(a_count), .spawn_pulse(a_spawn_pulse), .spawn_idx(a_spawn_idx),
        .kill_pulse(a_kill_pulse), .score(a_score), .escaped(a_escaped)
    );

    // Instance B: 4 slots, MIN = MAX = 4, 4-cycle death.
    logic        b_hit_valid = 1'b0, b_escape_valid = 1'b0;
    logic [1:0]  b_hit_idx = '0, b_escape_idx = '0;
    logic [3:0]  b_hit_dmg = '0;
    logic [3:0]  b_active, b_dying;
    logic [15:0] b_health;
    logic [7:0]  b_etype;
    logic [2:0]  b_count;
    logic        b_spawn_pulse, b_kill_pulse;
    logic [1:0]  b_spawn_idx;
    logic [15:0] b_score;
    logic [7:0]  b_escaped;

    enemy_pool_manager #(
        .N_SLOTS(4), .IDX_W(2), .MIN_ACTIVE(4), .MAX_ACTIVE(4),
        .HEALTH_W(4), .SPAWN_PERIOD(1000), .DEATH_CYCLES(4)
    ) dut_b (
        .clk(clk), .reset(reset),
        .hit_valid(b_hit_valid), .hit_idx(b_hit_idx), .hit_dmg(b_hit_dmg),
        .escape_valid(b_escape_valid), .escape_idx(b_escape_idx),
        .active(b_active), .dying(b_dying), .health(b_health), .etype(b_etype),
        .active_count(b_count), .spawn_pulse(b_spawn_pulse), .spawn_idx(b_spawn_idx),
        .kill_pulse(b_kill_pulse), .score(b_score), .escaped(b_escaped)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;

    typedef struct {
        bit kill;
        int idx;
        int edge_n;
        int score;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_ev;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_no <= 0;
        else       edge_no <= edge_no + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Enemy type of a slot spawned on edge n after reset release.
    function automatic logic [1:0] type_at(input int n);
        logic [7:0] l;
        l = 8'hA5;
        for (int k = 1; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l[1:0];
    endfunction

    task automatic push_spawn(input int idx, input int e);
        exp_q.push_back('{1'b0, idx, e, 0});
    endtask

    task automatic push_kill(input int idx, input int e, input int sc);
        exp_q.push_back('{1'b1, idx, e, sc});
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (edge_no < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 500) begin
                chk("goto_timeout", 32'(edge_no), 32'(n));
                return;
            end
        end
    endtask

    // Monitor: every pulse from instance A must match the next queued event.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_spawn_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_spawn_pulse", 32'(a_spawn_pulse), 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("spawn_idx", 32'(a_spawn_idx), mon_ev.kill ? 32'hDEAD : 32'(mon_ev.idx));
                    chk("spawn_edge", 32'(edge_no), 32'(mon_ev.edge_n));
                    chk("spawn_etype", 32'((a_etype >> (2*mon_ev.idx)) & 16'h3),
                        32'(type_at(mon_ev.edge_n)));
                    chk("spawn_health", 32'((a_health >> (4*mon_ev.idx)) & 32'hF),
                        32'(1) << type_at(mon_ev.edge_n));
                end
            end
            if (a_kill_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_kill_pulse", 32'(a_kill_pulse), 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("kill_score", 32'(a_score), mon_ev.kill ? 32'(mon_ev.score) : 32'hDEAD);
                    chk("kill_edge", 32'(edge_no), 32'(mon_ev.edge_n));
                    chk("kill_slot_dying", 32'(a_dying[mon_ev.idx]), 32'd1);
                end
            end
        end
    end

    task automatic clear_a();
        a_hit_valid    = 1'b0;
        a_escape_valid = 1'b0;
        a_hit_dmg      = '0;
    endtask

    task automatic run_a();
        goto(2);
        chk("a_active_init", 32'(a_active), 32'h03);
        chk("a_count_init", 32'(a_count), 32'd2);
        chk("a_etype_init", 32'(a_etype[3:0]), 32'h9);
        chk("a_health_init", 32'(a_health[7:0]), 32'h42);
        chk("a_score_init", 32'(a_score), 32'd0);

        a_hit_valid = 1'b1; a_hit_idx = 3'd0; a_hit_dmg = 4'd1;
        goto(3);
        chk("a_hit1_health", 32'(a_health[3:0]), 32'd1);
        chk("a_hit1_no_kill", 32'(a_kill_pulse), 32'd0);
        a_hit_dmg = 4'd5;
        goto(4);
        clear_a();
        chk("a_kill_health", 32'(a_health[3:0]), 32'd0);
        chk("a_kill_active0", 32'(a_active[0]), 32'd0);
        chk("a_kill_count", 32'(a_count), 32'd1);
        goto(5);
        chk("a_refill_active", 32'(a_active), 32'h06);
        chk("a_refill_count", 32'(a_count), 32'd2);
        goto(19);
        chk("a_dying_last", 32'(a_dying[0]), 32'd1);
        goto(20);
        chk("a_dying_freed", 32'(a_dying[0]), 32'd0);

        goto(69);
        chk("a_ceiling_active", 32'(a_active), 32'h3F);
        chk("a_ceiling_count", 32'(a_count), 32'd6);

        a_hit_valid = 1'b1; a_hit_idx = 3'd1; a_hit_dmg = 4'd1;
        a_escape_valid = 1'b1; a_escape_idx = 3'd1;
        goto(70);
        clear_a();
        chk("a_esc_active", 32'(a_active), 32'h3D);
        chk("a_esc_escaped", 32'(a_escaped), 32'd1);
        chk("a_esc_score", 32'(a_score), 32'd2);
        chk("a_esc_health", 32'(a_health[7:4]), 32'd0);
        chk("a_esc_count", 32'(a_count), 32'd5);

        goto(76);
        a_hit_valid = 1'b1; a_hit_idx = 3'd2; a_hit_dmg = 4'd1;
        a_escape_valid = 1'b1; a_escape_idx = 3'd2;
        goto(77);
        clear_a();
        chk("a_killesc_dying", 32'(a_dying[2]), 32'd1);
        chk("a_killesc_escaped", 32'(a_escaped), 32'd1);
        chk("a_killesc_count", 32'(a_count), 32'd5);

        a_hit_valid = 1'b1; a_hit_idx = 3'd7; a_hit_dmg = 4'd3;
        a_escape_valid = 1'b1; a_escape_idx = 3'd7;
        goto(78);
        clear_a();
        chk("a_free_escape_ignored", 32'(a_escaped), 32'd1);
        chk("a_free_hit_health", 32'(a_health[31:28]), 32'd0);
        chk("a_free_hit_active", 32'(a_active[7]), 32'd0);

        a_hit_valid = 1'b1; a_hit_idx = 3'd0; a_hit_dmg = 4'd0;
        goto(79);
        clear_a();
        chk("a_zero_dmg_health", 32'(a_health[3:0]), 32'(1) << type_at(25));

        goto(86);
        chk("a_late_active", 32'(a_active), 32'h7B);
        chk("a_late_count", 32'(a_count), 32'd6);

        goto(88);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_active", 32'(a_active), 32'd0);
        chk("rst_dying", 32'(a_dying), 32'd0);
        chk("rst_health", a_health, 32'd0);
        chk("rst_etype", 32'(a_etype), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_score", 32'(a_score), 32'd0);
        chk("rst_escaped", 32'(a_escaped), 32'd0);
        chk("rst_pulses", 32'({a_spawn_pulse, a_kill_pulse}), 32'd0);

        repeat (2) @(negedge clk);
        push_spawn(0, 1);
        push_spawn(1, 2);
        reset = 1'b0;
        goto(3);
        chk("a_rerun_active", 32'(a_active), 32'h03);
        chk("a_rerun_count", 32'(a_count), 32'd2);
        chk("a_rerun_etype", 32'(a_etype[3:0]), 32'h9);
        chk("a_rerun_health", 32'(a_health[7:0]), 32'h42);
    endtask

    task automatic run_b();
        goto(4);
        chk("b_full_active", 32'(b_active), 32'hF);
        chk("b_full_count", 32'(b_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            b_hit_valid = 1'b1; b_hit_idx = 2'(k); b_hit_dmg = 4'hF;
            goto(5 + k);
            chk("b_kill_pulse", 32'(b_kill_pulse), 32'd1);
            chk("b_no_spawn_while_full", 32'(b_spawn_pulse), 32'd0);
        end
        b_hit_valid = 1'b0;
        chk("b_all_dying", 32'(b_dying), 32'hF);
        chk("b_zero_count", 32'(b_count), 32'd0);
        chk("b_score", 32'(b_score), 32'd10);
        goto(9);
        chk("b_freed_no_spawn", 32'(b_spawn_pulse), 32'd0);
        chk("b_dying_after_free", 32'(b_dying), 32'hE);
        for (int k = 0; k < 4; k++) begin
            goto(10 + k);
            chk("b_refill_pulse", 32'(b_spawn_pulse), 32'd1);
            chk("b_refill_idx", 32'(b_spawn_idx), 32'(k));
        end
        chk("b_refill_active", 32'(b_active), 32'hF);
        chk("b_refill_count", 32'(b_count), 32'd4);
    endtask

    initial begin
        push_spawn(0, 1);
        push_spawn(1, 2);
        push_kill(0, 4, 2);
        push_spawn(2, 5);
        push_spawn(3, 15);
        push_spawn(0, 25);
        push_spawn(4, 35);
        push_spawn(5, 45);
        push_spawn(1, 75);
        push_kill(2, 77, 3);
        push_spawn(6, 85);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        fork
            run_a();
            run_b();
        join
        goto(6);
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
